// File: rtl/digi_ota_pkg.sv
// digi_ota_pkg: shared state type, pin map and dither LFSR constants
// for the OTA stimulus/readback controller.
package digi_ota_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      DONE
   } state_e;

   localparam int UI_SCLK  = 0;
   localparam int UI_SDATA = 1;
   localparam int UI_CS_N  = 2;
   localparam int UI_CMP   = 3;

   localparam int UO_DS    = 0;
   localparam int UO_VALID = 1;
   localparam int UO_ERR   = 2;
   localparam int UO_MEAS  = 3;
   localparam int UO_SETL  = 4;

   // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/digi_ota_sync.sv
// digi_ota_sync: multi-stage input synchronizer with edge detect;
// events appear STAGES+1 clocks after the pin changes.
module digi_ota_sync
   import digi_ota_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] ff_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff_q   <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         ff_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            ff_q[i] <= ff_q[i-1];
         end
         prev_q <= ff_q[STAGES-1];
      end
   end

   assign q_o    = ff_q[STAGES-1];
   assign rise_o = ff_q[STAGES-1] & ~prev_q;
   assign fall_o = ~ff_q[STAGES-1] & prev_q;

endmodule

// File: rtl/digi_ota_stim_ctrl.sv
// digi_ota_stim_ctrl: delta-sigma stimulus and comparator readback for the OTA.
// Optional LFSR dither on the modulator carry-in: DIGI_OTA_DITHER_EN.
module digi_ota_stim_ctrl
   import digi_ota_pkg::*;
#(
   parameter int ACC_W       = 8,
   parameter int WIN_LOG2    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int BC_W  = $clog2(ACC_W + 2);
   localparam int CNT_W = WIN_LOG2 + 1;
   localparam int SW    = ACC_W + 1;
   localparam int MAXV  = (1 << ACC_W) - 1;

   logic sclk_unused_q, sclk_rise, sclk_unused_fall;
   logic sdata_q, sdata_unused_rise, sdata_unused_fall;
   logic cs_q, cs_rise, cs_fall;
   logic cmp_q, cmp_unused_rise, cmp_unused_fall;
   logic unused_pins;

   logic [ACC_W-1:0]    sh_q, sh_d, code_q, code_d;
   logic [ACC_W-1:0]    acc_q, acc_d, uio_q, uio_d;
   logic [BC_W-1:0]     bc_q, bc_d;
   logic [WIN_LOG2-1:0] win_q, win_d;
   logic [CNT_W-1:0]    ones_q, ones_d, ones_nx;
   logic [SW-1:0]       sum;
   logic                err_q, err_d, ds_q, ds_d;
   logic                good, bad, win_end, cin;
   state_e              state_q, state_d;

   assign unused_pins = ^{ui_in[7:4], uio_in};

   digi_ota_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(ui_in[UI_SCLK]),
      .q_o(sclk_unused_q), .rise_o(sclk_rise), .fall_o(sclk_unused_fall)
   );

   digi_ota_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata (
      .clk(clk), .rst_n(rst_n), .d_i(ui_in[UI_SDATA]),
      .q_o(sdata_q), .rise_o(sdata_unused_rise), .fall_o(sdata_unused_fall)
   );

   // Idle-high reset value keeps reset release from looking like a frame end
   digi_ota_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst_n(rst_n), .d_i(ui_in[UI_CS_N]),
      .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   digi_ota_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cmp (
      .clk(clk), .rst_n(rst_n), .d_i(ui_in[UI_CMP]),
      .q_o(cmp_q), .rise_o(cmp_unused_rise), .fall_o(cmp_unused_fall)
   );

   assign good = cs_rise & (bc_q == BC_W'(ACC_W));
   assign bad  = cs_rise & (bc_q != BC_W'(ACC_W));

   always_comb begin
      sh_d   = sh_q;
      bc_d   = bc_q;
      code_d = code_q;
      err_d  = err_q;
      if (cs_fall) begin
         bc_d = '0;
      end else if (!cs_q && sclk_rise) begin
         sh_d = {sh_q[ACC_W-2:0], sdata_q};
         if (bc_q != BC_W'(ACC_W + 1)) bc_d = bc_q + BC_W'(1);
      end
      if (good) begin
         code_d = sh_q;
         err_d  = 1'b0;
      end else if (bad) begin
         err_d = 1'b1;
      end
   end

   assign win_end = (win_q == '1);

   always_comb begin
      state_d = state_q;
      if (!ena) begin
         state_d = IDLE;
      end else if (good) begin
         state_d = SETTLE;
      end else begin
         unique case (state_q)
            IDLE:    state_d = SETTLE;
            SETTLE:  if (win_end) state_d = MEASURE;
            MEASURE: if (win_end) state_d = DONE;
            DONE:    state_d = MEASURE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      win_d = win_q + WIN_LOG2'(1);
      if (state_d != state_q || good || state_d == IDLE) win_d = '0;
      ones_nx = ones_q + CNT_W'(cmp_q);
      ones_d  = '0;
      if (state_q == MEASURE && state_d == MEASURE) ones_d = ones_nx;
      uio_d = uio_q;
      if (state_q == MEASURE && state_d == DONE) begin
         if (int'(ones_nx) > MAXV) uio_d = '1;
         else uio_d = ACC_W'(ones_nx);
      end
   end

`ifdef DIGI_OTA_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   end

   assign cin = lfsr_q[0];
`else
   assign cin = 1'b0;
`endif

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, code_q} + SW'(cin);
      acc_d = sum[ACC_W-1:0];
      ds_d  = sum[ACC_W];
      if (state_d == IDLE) begin
         acc_d = '0;
         ds_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q    <= '0;
         bc_q    <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
         state_q <= IDLE;
         win_q   <= '0;
         ones_q  <= '0;
         uio_q   <= '0;
         acc_q   <= '0;
         ds_q    <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         bc_q    <= bc_d;
         code_q  <= code_d;
         err_q   <= err_d;
         state_q <= state_d;
         win_q   <= win_d;
         ones_q  <= ones_d;
         uio_q   <= uio_d;
         acc_q   <= acc_d;
         ds_q    <= ds_d;
      end
   end

   always_comb begin
      uo_out           = '0;
      uo_out[UO_DS]    = ds_q;
      uo_out[UO_VALID] = (state_q == DONE);
      uo_out[UO_ERR]   = err_q;
      uo_out[UO_MEAS]  = (state_q == MEASURE);
      uo_out[UO_SETL]  = (state_q == SETTLE);
   end

   assign uio_out = 8'(uio_q);
   assign uio_oe  = (state_q == IDLE) ? 8'h00 : 8'hFF;

endmodule

// File: doc/digi_ota_stim_ctrl.md
# digi_ota_stim_ctrl

- Digital stimulus and readback controller for the on-chip OTA macro.
- Generates a first-order delta-sigma bitstream on a digital pin; the external RC filters it into the OTA's input voltage.
- Samples the OTA's comparator-mode output back through a digital input and reports the fraction of ones over a fixed window.
- Sits in the tile's digital section, on the same TinyTapeout pin ring the analog OTA uses.

## Interface

Parameters:
- ACC_W, 8: code and accumulator width in bits.
- WIN_LOG2, 8: measurement window is 2^WIN_LOG2 clocks; the settle phase is the same length.
- SYNC_STAGES, 2: flip-flop stages on every asynchronous input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  tile enable; low forces IDLE.
- ui_in  in  8  [0] sclk, [1] sdata, [2] cs_n, [3] ota_cmp (OTA comparator output); [7:4] unused.
- uo_out  out  8  [0] ds_bit, [1] res_valid, [2] frame_err, [3] measuring, [4] settling; [7:5] tied 0.
- uio_in  in  8  unused.
- uio_out  out  8  last measurement result.
- uio_oe  out  8  8'h00 in reset and IDLE; 8'hFF otherwise.

## Operation

Reset values:
- All outputs 0.
- Code register 0.
- Accumulator 0.
- State IDLE.

Serial load:
- ui_in[2:0] pass through SYNC_STAGES synchronizers.
- While cs_n is low, each synchronized rising edge of sclk shifts sdata into the shift register, MSB first.
- A bit counter counts the shifts and saturates at ACC_W+1.
- On the cs_n rising edge with exactly ACC_W bits shifted:
  - code takes the shift register value;
  - frame_err clears;
  - the FSM restarts at SETTLE.
- Any other bit count: the frame is discarded and frame_err is set (sticky until the next good frame).
- A cs_n falling edge clears the bit counter.

Modulator:
- Running in SETTLE, MEASURE and DONE: {carry, acc} = acc + code, and ds_bit is registered as carry.
- ds_bit density = code / 2^ACC_W.
  - code 0 gives a constant 0.
  - code 255 gives 255 ones in every 256 clocks.
- In IDLE: acc is held at 0 and ds_bit = 0.

FSM (one-hot or encoded):
- IDLE -> SETTLE when ena=1. Any state -> IDLE when ena=0.
- SETTLE: runs for 2^WIN_LOG2 clocks with the comparator ignored and settling=1, then -> MEASURE.
- MEASURE: runs for 2^WIN_LOG2 clocks with measuring=1. The ones counter (WIN_LOG2+1 bits) increments on each synchronized ota_cmp=1. Then -> DONE.
- DONE: one clock.
  - uio_out takes min(count, 2^ACC_W - 1), saturating.
  - res_valid=1 for exactly this clock.
  - count clears, then -> MEASURE for continuous back-to-back windows.
- A good frame arriving in any state forces SETTLE and clears the window and ones counters. uio_out keeps its last value.

## Timing

- Input synchronization: edge detect adds SYNC_STAGES+1 clocks of latency from a pin change to the internal event.
- sclk high and low phases must each be ≥ SYNC_STAGES+2 clocks; faster sclk is out of spec.
- ds_bit is registered, so there is one clock from the accumulator update to the pin.
- Good-frame latency: cs_n rising at the pin -> code update and SETTLE entry after SYNC_STAGES+1 clocks.
- First res_valid comes 2^(WIN_LOG2+1)+1 clocks after SETTLE entry. Thereafter it repeats every 2^WIN_LOG2+1 clocks.
- Simultaneous events:
  - good frame and DONE in the same clock: the frame wins; no res_valid and no uio_out update.
  - ena low and DONE in the same clock: IDLE wins.
- Reset mid-frame: the shift register and bit counter clear, and the partial frame is lost without setting frame_err.

## Configuration

- DIGI_OTA_DITHER_EN:
  - Defined: a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances every clock and its LSB is added as a carry-in to the accumulator sum. This breaks idle tones at codes near 0 and 2^ACC_W-1. The LFSR resets to its seed.
  - Undefined: no LFSR; the modulator is the pure deterministic accumulator above.
- All other behaviour is identical in both builds.

## Structure

- Package digi_ota_pkg holds:
  - the state enum (IDLE, SETTLE, MEASURE, DONE);
  - pin index constants for ui_in and uo_out fields;
  - the LFSR seed and tap constants.
- One sub-module, digi_ota_sync: a parameterized SYNC_STAGES flip-flop synchronizer with a rising/falling edge detect. It is instantiated for sclk, sdata, cs_n and ota_cmp.
- The top contains the shift loader, modulator, FSM and counters.

## Test plan

- Reset and code 0:
  - Stimulus: rst_n low 4 clocks, then ena=1 with no frame.
  - Required: all outputs 0 during reset; ds_bit stays 0; with ota_cmp=0, uio_out=0 and res_valid pulses at clock 513, then every 257.
- Density:
  - Stimulus: load code 8'h40; loop ds_bit back to ota_cmp through the bench.
  - Required (dither off): exactly 64 ones per 256-clock window; uio_out=64.
- Saturation:
  - Stimulus: ota_cmp held 1.
  - Required: count reaches 256; uio_out=255 (8'hFF).
- Frame error:
  - Stimulus: a 7-bit frame, then a 9-bit frame.
  - Required: frame_err=1 and the code is unchanged after each. A following 8-bit frame 8'hC3 clears frame_err and sets code=8'hC3.
- Frame collides with DONE:
  - Stimulus: time the cs_n rising edge so its internal event lands on the DONE clock.
  - Required: no res_valid; settling=1 on the next clock; uio_out holds its prior value.
- Disable mid-measure:
  - Stimulus: ena=0 for 1 clock during MEASURE.
  - Required: IDLE, ds_bit=0 and uio_oe=8'h00 next clock. Re-enable restarts SETTLE.
